// File: rtl/complex_res_fifo_if.sv
// Handshake and status bundle between the complex multiplier, the result FIFO and its consumer.
interface complex_res_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    logic                        in_val;
    logic                        in_ready;
    logic [2*DATA_WIDTH-1:0]     in_re;
    logic [2*DATA_WIDTH-1:0]     in_im;
    logic                        out_val;
    logic                        out_ready;
    logic [2*DATA_WIDTH-1:0]     out_re;
    logic [2*DATA_WIDTH-1:0]     out_im;
    logic [$clog2(DEPTH):0]      count;
    logic                        full;
    logic                        empty;

    modport master (
        output in_val, in_re, in_im, out_ready,
        input  in_ready, out_val, out_re, out_im, count, full, empty
    );

    modport slave (
        input  in_val, in_re, in_im, out_ready,
        output in_ready, out_val, out_re, out_im, count, full, empty
    );
endinterface

// File: rtl/complex_res_fifo.sv
// First-word-fall-through result buffer decoupling the complex multiplier from a stalling consumer.
module complex_res_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sw_rst,
    complex_res_fifo_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = 2 * DATA_WIDTH;

    logic [2*WW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign push  = bus.in_val & ~full;
    assign pop   = bus.out_ready & ~empty;

    always_ff @(posedge clk) begin
        if (!rstn || sw_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Contents are never cleared; the empty gate on the outputs hides stale words.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.in_re, bus.in_im};
    end

    assign bus.in_ready = ~full;
    assign bus.out_val  = ~empty;
    assign bus.out_re   = empty ? '0 : mem[rd_ptr][2*WW-1:WW];
    assign bus.out_im   = empty ? '0 : mem[rd_ptr][WW-1:0];
    assign bus.count    = cnt;
    assign bus.full     = full;
    assign bus.empty    = empty;
endmodule

// File: tb/tb_complex_res_fifo.sv
// Directed bench for complex_res_fifo with a queue reference model checked every cycle.
module tb_complex_res_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstn;
    logic sw_rst;
    int   vectors = 0;
    int   miscompares = 0;
    bit   check_en = 1'b0;

    logic [31:0] model_q[$];

    complex_res_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    complex_res_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sw_rst (sw_rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of {re, im} words of at most DEPTH entries.
    always @(posedge clk) begin
        if (!rstn || sw_rst) begin
            model_q.delete();
        end else begin
            automatic bit do_push = bus.in_val && (model_q.size() < DEPTH);
            automatic bit do_pop  = bus.out_ready && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({bus.in_re, bus.in_im});
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            automatic int n = model_q.size();
            chk("count",    32'(bus.count),    32'(n));
            chk("full",     32'(bus.full),     32'(n == DEPTH));
            chk("empty",    32'(bus.empty),    32'(n == 0));
            chk("in_ready", 32'(bus.in_ready), 32'(n != DEPTH));
            chk("out_val",  32'(bus.out_val),  32'(n != 0));
            chk("out_re",   32'(bus.out_re),   (n != 0) ? 32'(model_q[0][31:16]) : 32'd0);
            chk("out_im",   32'(bus.out_im),   (n != 0) ? 32'(model_q[0][15:0])  : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [15:0] re, input logic [15:0] im);
        bus.in_val = 1'b1;
        bus.in_re  = re;
        bus.in_im  = im;
        step();
        bus.in_val = 1'b0;
    endtask

    logic [15:0] exp_drain [5];
    logic [15:0] wrap_got [$];
    int          pushed;
    int          cycles;

    initial begin
        rstn          = 1'b0;
        sw_rst        = 1'b0;
        bus.in_val    = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;

        // Reset held for two edges
        step();
        check_en = 1'b1;
        step();
        rstn = 1'b1;
        chk("rst_out_val",  32'(bus.out_val),  32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count",    32'(bus.count),    32'd0);
        chk("rst_empty",    32'(bus.empty),    32'd1);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_out_re",   32'(bus.out_re),   32'd0);
        chk("rst_out_im",   32'(bus.out_im),   32'd0);

        // Single transfer
        push1(16'h0012, 16'h00A5);
        chk("single_val",   32'(bus.out_val), 32'd1);
        chk("single_re",    32'(bus.out_re),  32'h0012);
        chk("single_im",    32'(bus.out_im),  32'h00A5);
        chk("single_count", 32'(bus.count),   32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("single_empty", 32'(bus.empty), 32'd1);
        chk("single_cnt0",  32'(bus.count), 32'd0);

        // Fill, stall, then drain with a held fifth word
        for (int k = 1; k <= 4; k++) push1(16'(k), 16'(16'h0100 + k));
        chk("fill_full",  32'(bus.full),     32'd1);
        chk("fill_ready", 32'(bus.in_ready), 32'd0);
        bus.in_val = 1'b1;
        bus.in_re  = 16'h0005;
        bus.in_im  = 16'h0105;
        step();
        step();
        chk("stall_count", 32'(bus.count), 32'd4);
        chk("stall_head",  32'(bus.out_re), 32'h0001);
        for (int i = 0; i < 5; i++) exp_drain[i] = 16'(i + 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            automatic bit acc = bus.in_val && bus.in_ready;
            chk("drain_re", 32'(bus.out_re), 32'(exp_drain[i]));
            chk("drain_im", 32'(bus.out_im), 32'(16'h0100 + exp_drain[i]));
            step();
            if (acc) bus.in_val = 1'b0;
        end
        bus.out_ready = 1'b0;
        chk("drain_in_val_cleared", 32'(bus.in_val), 32'd0);
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Simultaneous push and pop at count 2
        push1(16'h0021, 16'h0A21);
        push1(16'h0022, 16'h0A22);
        bus.out_ready = 1'b1;
        push1(16'h0023, 16'h0A23);
        bus.out_ready = 1'b0;
        chk("sim_count", 32'(bus.count),  32'd2);
        chk("sim_head",  32'(bus.out_re), 32'h0022);
        bus.out_ready = 1'b1;
        step();
        chk("sim_next",  32'(bus.out_re), 32'h0023);
        chk("sim_next_im", 32'(bus.out_im), 32'h0A23);
        step();
        bus.out_ready = 1'b0;
        chk("sim_empty", 32'(bus.empty), 32'd1);

        // Interleaved traffic with random consumer stalls across pointer wrap
        pushed = 0;
        cycles = 0;
        wrap_got.delete();
        while ((pushed < 10 || wrap_got.size() < 10) && cycles < 200) begin
            automatic bit acc;
            bus.in_val    = (pushed < 10) && ($urandom_range(0, 3) != 0);
            bus.in_re     = 16'(16'h0300 + pushed);
            bus.in_im     = 16'(16'hC000 + 3 * pushed);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            acc = bus.in_val && bus.in_ready;
            if (bus.out_val && bus.out_ready) wrap_got.push_back(bus.out_re);
            step();
            if (acc) pushed++;
            cycles++;
        end
        bus.in_val    = 1'b0;
        bus.out_ready = 1'b0;
        chk("wrap_done", 32'(wrap_got.size()), 32'd10);
        for (int i = 0; i < wrap_got.size() && i < 10; i++)
            chk("wrap_order", 32'(wrap_got[i]), 32'(16'h0300 + i));

        // Software reset mid-operation with concurrent push and pop
        push1(16'h0041, 16'h0B41);
        push1(16'h0042, 16'h0B42);
        push1(16'h0043, 16'h0B43);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        sw_rst        = 1'b1;
        bus.out_ready = 1'b1;
        push1(16'h0099, 16'h0B99);
        sw_rst        = 1'b0;
        bus.out_ready = 1'b0;
        chk("swrst_count",   32'(bus.count),   32'd0);
        chk("swrst_empty",   32'(bus.empty),   32'd1);
        chk("swrst_out_val", 32'(bus.out_val), 32'd0);
        step();
        chk("swrst_discard", 32'(bus.out_val), 32'd0);

        // Reset release then immediate push
        push1(16'h0055, 16'h0B55);
        chk("post_rst_re", 32'(bus.out_re), 32'h0055);

        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/complex_res_fifo.md
# complex_res_fifo

Result buffer sitting directly downstream of the complex multiplier. It accepts each (real, imaginary) product over a valid/ready handshake and stores up to DEPTH results in first-in, first-out order. It presents them to the consumer with first-word-fall-through behaviour. Its purpose is to decouple the multiplier's res_val/res_ready handshake from a consumer that stalls, so the multiplier is not held back beyond FIFO capacity.

## Interface
- DATA_WIDTH, 8: operand width of the multiplier; every stored word is 2*DATA_WIDTH bits per part.
- DEPTH, 4: number of entries; must be a power of two, at least 2.

- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset; synchronous, active-low (one clock; reset is synchronous and active-low).
- sw_rst  input  1  software reset, active 1, synchronous; same effect as rstn.
- in_val  input  1  upstream result valid; connects to multiplier res_val.
- in_ready  output  1  FIFO can accept; connects to multiplier res_ready.
- in_re  input  2*DATA_WIDTH  real part of incoming result.
- in_im  input  2*DATA_WIDTH  imaginary part of incoming result.
- out_val  output  1  head entry available to consumer.
- out_ready  input  1  consumer takes head entry.
- out_re  output  2*DATA_WIDTH  real part of head entry.
- out_im  output  2*DATA_WIDTH  imaginary part of head entry.
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

## Operation
- Storage: DEPTH x (2*2*DATA_WIDTH) register array, write pointer wr_ptr, read pointer rd_ptr (each $clog2(DEPTH) bits, wrap modulo DEPTH), occupancy counter cnt.
- Push: occurs when in_val & in_ready at a clock edge. {in_re, in_im} is written at wr_ptr, then wr_ptr increments.
- Pop: occurs when out_val & out_ready at a clock edge. rd_ptr increments.
- in_ready = ~full. There is no pass-through when full, even if a pop occurs in the same cycle.
- out_val = ~empty.
- out_re/out_im = array[rd_ptr] when not empty, else all zeros.
- cnt update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop (possible when 0 < cnt < DEPTH).
- Data passes through unmodified; widths are not altered, and there is no sign or overflow handling.
- Pointer wrap: incrementing from DEPTH−1 returns to 0. Order is preserved across the wrap.
- Reset (rstn low or sw_rst high at an edge):
  - wr_ptr, rd_ptr and cnt go to 0.
  - Resulting outputs: in_ready=1, out_val=0, out_re=out_im=0, count=0, full=0, empty=1.
  - Array contents need not be cleared; they are invisible because outputs are gated while empty.
  - rstn takes priority over sw_rst; both take priority over push and pop in the same cycle.
  - Reset mid-operation discards all stored entries, and a push or pop in that cycle is ignored.
- Protocol rules:
  - Upstream holds in_re/in_im stable while in_val=1 and in_ready=0.
  - The FIFO holds out_re/out_im stable while out_val=1 and out_ready=0.
  - out_ready while empty has no effect.
  - in_val while full has no effect, and no data is lost: the entry is retried by upstream.

## Timing
- Latency: a push at edge N makes the entry visible at out_* after edge N if the FIFO was empty. out_val rises in the cycle following the push edge.
- A pop at edge N presents the next entry, or clears out_val, after edge N.
- full, empty, count and in_ready are pure functions of registered cnt. There are no combinational paths from in_val or out_ready to any output.
- Sustained throughput is one result per cycle when 0 < cnt < DEPTH and both sides are active.
- Reset takes effect at the first rising edge with rstn=0. The FIFO accepts a push at the first edge with rstn=1 and sw_rst=0.

## Test plan
- Reset: hold rstn=0 for 2 cycles, then release. Required: out_val=0, in_ready=1, count=0, empty=1, full=0, out_re=out_im=0.
- Single transfer: push in_re=0x0012, in_im=0x00A5 with out_ready=0. Required: next cycle out_val=1, out_re=0x0012, out_im=0x00A5, count=1. Then assert out_ready for one cycle. Required: empty=1, count=0.
- Fill and stall (DEPTH=4): push 1,2,3,4 (re=k, im=0x100+k) with out_ready=0. Required: full=1, in_ready=0. A 5th push held with in_val=1 is not accepted and count stays 4. Then drain. Required: values emerge as 1,2,3,4 in order, and the held 5th value is accepted once in_ready=1.
- Simultaneous push/pop with count=2: push and pop in the same cycle. Required: count stays 2, the head advances, and the new entry appears after the existing one.
- Wrap-around: run 10 pushes and pops interleaved with random out_ready stalls, never exceeding DEPTH. Required: output sequence identical to input sequence, pointers wrap, and no entry is lost or duplicated.
- Reset mid-operation: with count=3, assert sw_rst=1 together with in_val=1 and out_ready=1 for one cycle. Required: count=0, empty=1, out_val=0 the next cycle, and the concurrent push is discarded.
